mesh_hs_monitor: RTL
====================

Name: mesh_hs_monitor

Overview:
- Synthesizable, parametrised successor to the mesh bench's interface handshake assertions; watches every terminal of the mesh_gnrtr router.
- Covers both directions per terminal: router-out (pndng/pop) and router-in (pndng_i_in/popin).
- Per-direction FSM measures pending-to-pop latency, flags timeout/early/drop/spurious-pop violations, and keeps saturating statistics readable through a select port.
- Sits beside the DUT in the bench, and can be bound into an emulation build.

Parameters:
- NUM_CH, 16, number of terminals (ROWS*COLUMS).
- PCKG_SZ, 40, packet width in bits.
- MAX_LAT, 10, maximum legal pending-to-pop latency in cycles (>=1).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- pndng  in  NUM_CH  router-out pending per terminal.
- pop  in  NUM_CH  router-out pop per terminal.
- pndng_i_in  in  NUM_CH  router-in pending per terminal.
- popin  in  NUM_CH  router-in pop per terminal.
- data_out  in  NUM_CH*PCKG_SZ  router-out data, terminal i at bits [i*PCKG_SZ +: PCKG_SZ].
- data_out_i_in  in  NUM_CH*PCKG_SZ  router-in data, same packing.
- clr  in  1  synchronous clear of sticky flags and counters.
- rd_sel  in  $clog2(2*NUM_CH)  stats select: even = out dir of terminal sel/2, odd = in dir.
- rd_pass  out  CNT_W  legal handshakes on the selected direction.
- rd_err  out  CNT_W  violations on the selected direction.
- rd_maxlat  out  $clog2(MAX_LAT+2)  worst legal latency seen on the selected direction.
- err_sticky  out  2*NUM_CH  per-direction sticky violation flag, same indexing as rd_sel.
- err_any  out  1  OR of err_sticky.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-high (reset).
- Reset (async assert, sync release): every FSM goes to IDLE; all counters, registered pending history and outputs are 0.
- Reset mid-handshake: the handshake is discarded and no error is logged.
- Rise detection: rise = pend & ~pend_q, with pend_q registered. Pending already high on the first cycle after reset counts as a rise.
- FSM states per direction:
  - IDLE:
    - rise with pop in the same cycle -> early error, go to ERR.
    - rise without pop -> WAIT, lat=1.
    - pop while pending is low -> spurious-pop error, stay IDLE.
  - WAIT (latency counter lat):
    - pop with lat<=MAX_LAT -> pass, update maxlat, go to IDLE.
    - pending falls without pop -> drop error, go to IDLE.
    - lat==MAX_LAT without pop -> timeout error, go to ERR.
    - otherwise lat++.
  - ERR: hold until pending is low, then go to IDLE. A pop while in ERR is ignored (not re-counted).
- Legal window is pop 1..MAX_LAT cycles after the rise.
- Counters:
  - rd_pass and rd_err saturate at all-ones.
  - rd_maxlat is the maximum of lat over passes.
- Error reporting latency: err_sticky bit and err count update on the clock edge after the violating cycle; err_any follows combinationally from err_sticky.
- rd_* outputs are combinational muxes of the registered stats. rd_sel >= 2*NUM_CH returns 0.
- clr: zeroes sticky flags, counters and maxlat. FSM state is not affected.
  - If clr and a new violation occur in the same cycle, the violation wins: flag = 1, err count = 1.
  - If clr and a pass occur in the same cycle, pass count = 1.
- Directions and channels are fully independent; simultaneous events on different channels are all counted in the same cycle.

Optional Feature:
- Macro: MESH_HS_DATA_CHK_EN.
- Defined: data for the direction is registered on entry to WAIT. A change of data while in WAIT is a stability error (sets sticky, increments err, FSM stays in WAIT).
- Undefined: no data registers; data_out and data_out_i_in are ignored, and the stability check and its storage are absent.

Decomposition:
- Package mesh_hs_pkg holds:
  - state enum hs_state_e {IDLE, WAIT, ERR};
  - err_kind_e {EARLY, TIMEOUT, DROP, SPURIOUS, DATA};
  - function lat_w(MAX_LAT) returning the latency counter width.
- Sub-module mesh_hs_dir: one direction of one terminal (FSM, lat, counters, optional data check).
- Top generates 2*NUM_CH instances and the rd mux.

Test Plan:
- Terminal 3 out: pndng rises at cycle 100, pop at 104 -> rd_sel=6 gives rd_pass=1, rd_err=0, rd_maxlat=4; err_any=0.
- Terminal 0 in: pndng_i_in held high 12 cycles with no popin (MAX_LAT=10) -> err_sticky[1]=1 the cycle after lat reaches 10, rd_err=1; pop at cycle 12 is not counted.
- Terminal 5 out: pop=1 with pndng=0 -> err_sticky[10]=1, rd_err=1. Then clr together with a new spurious pop -> rd_err=1, flag remains 1.
- Terminal 15 out: pndng rises with pop in the same cycle -> early error; pndng rises, then falls after 3 cycles with no pop -> drop error; rd_err=2 total.
- Terminal 7 in: reset asserted mid-WAIT at lat=5 -> all outputs 0 asynchronously; after release, pndng_i_in still high counts as a new rise, and popin 2 cycles later gives rd_pass=1.
- With MESH_HS_DATA_CHK_EN defined: terminal 2 out data changes from 0x1 to 0x2 in WAIT, then pop -> rd_err=1, rd_pass=1. Without the macro -> rd_err=0.

Source files
------------

// File: rtl/mesh_hs_pkg.sv
// Shared types and helpers for the mesh handshake monitor.
// Optional data-stability check is enabled with MESH_HS_DATA_CHK_EN.
package mesh_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hs_state_e;

  typedef enum logic [2:0] {
    EARLY    = 3'd0,
    TIMEOUT  = 3'd1,
    DROP     = 3'd2,
    SPURIOUS = 3'd3,
    DATA     = 3'd4
  } err_kind_e;

  // Wide enough to hold MAX_LAT plus one spare code.
  function automatic int lat_w(input int max_lat);
    return $clog2(max_lat + 2);
  endfunction

endpackage

// File: rtl/mesh_hs_dir.sv
// One handshake direction of one terminal: FSM, latency counter, stats.
// MESH_HS_DATA_CHK_EN adds a data-stability check while waiting for pop.
module mesh_hs_dir import mesh_hs_pkg::*; #(
  parameter int PCKG_SZ = 40,
  parameter int MAX_LAT = 10,
  parameter int CNT_W   = 16,
  localparam int LW     = lat_w(MAX_LAT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pend,
  input  logic               pop,
  input  logic [PCKG_SZ-1:0] data,
  input  logic               clr,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [LW-1:0]      maxlat,
  output logic               sticky
);

  hs_state_e       state, state_nx;
  logic            pend_q;
  logic [LW-1:0]   lat, lat_nx;
  logic            rise;
  logic            pass_ev;
  logic            err_ev;
  logic [4:0]      err_vec;

`ifdef MESH_HS_DATA_CHK_EN
  logic [PCKG_SZ-1:0] data_q, data_nx;
`else
  logic unused_data;
  assign unused_data = ^data;
`endif

  assign rise   = pend & ~pend_q;
  assign err_ev = |err_vec;

  always_comb begin
    state_nx = state;
    lat_nx   = lat;
    pass_ev  = 1'b0;
    err_vec  = '0;
`ifdef MESH_HS_DATA_CHK_EN
    data_nx  = data_q;
`endif
    case (state)
      IDLE: begin
        if (rise && pop) begin
          err_vec[EARLY] = 1'b1;
          state_nx       = ERR;
        end else if (rise) begin
          state_nx = WAIT;
          lat_nx   = LW'(1);
`ifdef MESH_HS_DATA_CHK_EN
          data_nx  = data;
`endif
        end else if (pop && !pend) begin
          err_vec[SPURIOUS] = 1'b1;
        end
      end
      WAIT: begin
        if (pop && (lat <= LW'(MAX_LAT))) begin
          pass_ev  = 1'b1;
          state_nx = IDLE;
        end else if (!pend) begin
          err_vec[DROP] = 1'b1;
          state_nx      = IDLE;
        end else if (lat == LW'(MAX_LAT)) begin
          err_vec[TIMEOUT] = 1'b1;
          state_nx         = ERR;
        end else begin
          lat_nx = lat + LW'(1);
        end
`ifdef MESH_HS_DATA_CHK_EN
        // Track the new value so one change is reported once.
        if (data != data_q) begin
          err_vec[DATA] = 1'b1;
          data_nx       = data;
        end
`endif
      end
      ERR: begin
        if (!pend) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pend_q <= 1'b0;
      lat    <= '0;
`ifdef MESH_HS_DATA_CHK_EN
      data_q <= '0;
`endif
    end else begin
      state  <= state_nx;
      pend_q <= pend;
      lat    <= lat_nx;
`ifdef MESH_HS_DATA_CHK_EN
      data_q <= data_nx;
`endif
    end
  end

  // A same-cycle event survives clr so nothing is lost at the clear boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_cnt <= '0;
      err_cnt  <= '0;
      maxlat   <= '0;
      sticky   <= 1'b0;
    end else if (clr) begin
      pass_cnt <= pass_ev ? CNT_W'(1) : '0;
      err_cnt  <= err_ev ? CNT_W'(1) : '0;
      maxlat   <= pass_ev ? lat : '0;
      sticky   <= err_ev;
    end else begin
      if (pass_ev && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (err_ev && (err_cnt != '1))   err_cnt  <= err_cnt + CNT_W'(1);
      if (pass_ev && (lat > maxlat))   maxlat   <= lat;
      if (err_ev)                      sticky   <= 1'b1;
    end
  end

endmodule

// File: rtl/mesh_hs_monitor.sv
// Handshake monitor for every terminal of the mesh router, both directions.
// Define MESH_HS_DATA_CHK_EN to enable the data-stability check.
module mesh_hs_monitor import mesh_hs_pkg::*; #(
  parameter int NUM_CH  = 16,
  parameter int PCKG_SZ = 40,
  parameter int MAX_LAT = 10,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             pndng,
  input  logic [NUM_CH-1:0]             pop,
  input  logic [NUM_CH-1:0]             pndng_i_in,
  input  logic [NUM_CH-1:0]             popin,
  input  logic [NUM_CH*PCKG_SZ-1:0]     data_out,
  input  logic [NUM_CH*PCKG_SZ-1:0]     data_out_i_in,
  input  logic                          clr,
  input  logic [$clog2(2*NUM_CH)-1:0]   rd_sel,
  output logic [CNT_W-1:0]              rd_pass,
  output logic [CNT_W-1:0]              rd_err,
  output logic [lat_w(MAX_LAT)-1:0]     rd_maxlat,
  output logic [2*NUM_CH-1:0]           err_sticky,
  output logic                          err_any
);

  localparam int ND = 2 * NUM_CH;
  localparam int LW = lat_w(MAX_LAT);

  logic [CNT_W-1:0] pass_a [ND];
  logic [CNT_W-1:0] err_a  [ND];
  logic [LW-1:0]    ml_a   [ND];

  // Even index = router-out direction, odd index = router-in direction.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mesh_hs_dir #(
      .PCKG_SZ (PCKG_SZ),
      .MAX_LAT (MAX_LAT),
      .CNT_W   (CNT_W)
    ) u_out (
      .clk      (clk),
      .reset    (reset),
      .pend     (pndng[i]),
      .pop      (pop[i]),
      .data     (data_out[i*PCKG_SZ +: PCKG_SZ]),
      .clr      (clr),
      .pass_cnt (pass_a[2*i]),
      .err_cnt  (err_a[2*i]),
      .maxlat   (ml_a[2*i]),
      .sticky   (err_sticky[2*i])
    );

    mesh_hs_dir #(
      .PCKG_SZ (PCKG_SZ),
      .MAX_LAT (MAX_LAT),
      .CNT_W   (CNT_W)
    ) u_in (
      .clk      (clk),
      .reset    (reset),
      .pend     (pndng_i_in[i]),
      .pop      (popin[i]),
      .data     (data_out_i_in[i*PCKG_SZ +: PCKG_SZ]),
      .clr      (clr),
      .pass_cnt (pass_a[2*i+1]),
      .err_cnt  (err_a[2*i+1]),
      .maxlat   (ml_a[2*i+1]),
      .sticky   (err_sticky[2*i+1])
    );
  end

  assign err_any = |err_sticky;

  always_comb begin
    rd_pass   = '0;
    rd_err    = '0;
    rd_maxlat = '0;
    if (int'(rd_sel) < ND) begin
      rd_pass   = pass_a[rd_sel];
      rd_err    = err_a[rd_sel];
      rd_maxlat = ml_a[rd_sel];
    end
  end

endmodule
